// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared constants and FSM state encoding for the UART TX arbiter.
// Revision : 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int         c_N_REQ       = 4;
    localparam int         c_IDX_W       = 2;
    localparam logic [7:0] c_HEADER_BASE = 8'hA0;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SEND_HDR  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_HDR  = 3'd2;
    localparam logic [2:0] c_ST_SEND_DATA = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DATA = 3'd4;
    localparam logic [2:0] c_ST_ACK       = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_SEND_HDR  = c_ST_SEND_HDR,
        ST_WAIT_HDR  = c_ST_WAIT_HDR,
        ST_SEND_DATA = c_ST_SEND_DATA,
        ST_WAIT_DATA = c_ST_WAIT_DATA,
        ST_ACK       = c_ST_ACK
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_rr_pick
// Brief    : Round-robin winner select, searching from last_owner+1 upward.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [c_IDX_W-1:0] last_owner,
    output logic               valid,
    output logic [c_IDX_W-1:0] index
);

    logic [c_IDX_W-1:0] w_cand;

    // Scan farthest offset first so the nearest requester after last_owner wins.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = last_owner + k[c_IDX_W-1:0];
            if (req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one uart_tx among four requesters; sends header + payload.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         N_REQ          = c_N_REQ,
    parameter logic [7:0] HEADER_BASE    = c_HEADER_BASE,
    parameter int         TIMEOUT_CYCLES = 60000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic                 tx_start,
    output logic [7:0]           tx_writedata,
    input  logic                 tx_done
);

    localparam logic [15:0]      c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] c_ONE          = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [c_IDX_W-1:0] r_index;
    logic [c_IDX_W-1:0] r_last_owner;
    logic [7:0]         r_payload;
    logic [15:0]        r_wait_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;
    logic               r_err;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;

    logic               w_pick_valid;
    logic [c_IDX_W-1:0] w_pick_index;
    logic               w_timeout;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .valid      (w_pick_valid),
        .index      (w_pick_index)
    );

    assign w_timeout = (r_wait_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_last_owner <= '1;
            r_payload    <= '0;
            r_wait_cnt   <= '0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_err        <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_index    <= w_pick_index;
                        r_payload  <= req_data[8*w_pick_index +: 8];
                        r_grant    <= c_ONE << w_pick_index;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= HEADER_BASE | {{(8-c_IDX_W){1'b0}}, w_pick_index};
                        r_state    <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_HDR;
                end
                ST_WAIT_HDR: begin
                    if (tx_done) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_payload;
                        r_state    <= ST_SEND_DATA;
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_grant      <= '0;
                        r_last_owner <= r_index;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_SEND_DATA: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (tx_done) begin
                        r_ack   <= c_ONE << r_index;
                        r_state <= ST_ACK;
                    end else if (w_timeout) begin
                        r_err        <= 1'b1;
                        r_grant      <= '0;
                        r_last_owner <= r_index;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_ACK: begin
                    r_grant      <= '0;
                    r_last_owner <= r_index;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign ack          = r_ack;
    assign err          = r_err;
    assign tx_start     = r_tx_start;
    assign tx_writedata = r_tx_data;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter HEADER_BASE, default 8'hA0, header byte base; header = HEADER_BASE | requester index.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 60000, maximum cycles to wait for tx_done per byte (> 11 bit times at 5208 clocks/bit).
REQ-004 SHALL have port clock  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  4  per-requester transfer request, level.
REQ-007 SHALL have port req_data  input  32  payload bytes; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port grant  output  4  one-hot owner of the transmitter; all-zero when idle.
REQ-009 SHALL have port ack  output  4  one-cycle pulse on the owner's bit after both bytes are sent.
REQ-010 SHALL have port err  output  1  one-cycle pulse on timeout abort.
REQ-011 SHALL have port tx_start  output  1  one-cycle start strobe to the shared uart_tx.
REQ-012 SHALL have port tx_writedata  output  8  byte to transmit; valid while tx_start is high.
REQ-013 SHALL have port tx_done  input  1  one-cycle pulse from uart_tx at end of its stop bit.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND_HDR, WAIT_HDR, SEND_DATA, WAIT_DATA, ACK.
REQ-015 In IDLE with req != 0, SHALL select a winner by round-robin starting at index (last_owner+1) mod 4, latch its index and req_data byte, set grant one-hot, and move to SEND_HDR on the same edge.
REQ-016 In SEND_HDR, SHALL assert tx_start for exactly one cycle with tx_writedata = HEADER_BASE | index, then move to WAIT_HDR.
REQ-017 In WAIT_HDR, SHALL move to SEND_DATA on the cycle after tx_done is sampled high.
REQ-018 In SEND_DATA, SHALL assert tx_start for one cycle with tx_writedata = latched payload, then move to WAIT_DATA.
REQ-019 In WAIT_DATA, SHALL move to ACK when tx_done is sampled high.
REQ-020 In ACK, SHALL pulse ack[index] for one cycle, clear grant, set last_owner = index, and return to IDLE.
REQ-021 Latency: grant SHALL rise at edge N+1 after req is sampled in IDLE at edge N, with tx_start high during cycle N+1.
REQ-022 Payload SHALL be latched at grant; req_data or req changes afterwards SHALL NOT affect the transfer, and a dropped req SHALL still receive its ack.
REQ-023 tx_done SHALL be ignored in IDLE, SEND_HDR, SEND_DATA and ACK.
REQ-024 In WAIT_HDR and WAIT_DATA, a 16-bit wait counter SHALL clear on entry; on reaching TIMEOUT_CYCLES it SHALL pulse err, clear grant, update last_owner, return to IDLE, and suppress ack.
REQ-025 A requester holding req after ack SHALL be treated as a new request, with other pending requesters winning first.
REQ-026 The minimum gap SHALL be one IDLE cycle between ack and the next grant.
REQ-027 grant, tx_start, ack and err SHALL be Moore outputs decoded from registered state/index only.

Reset
REQ-028 While reset is high at a clock edge: state=IDLE, grant=0, ack=0, err=0, tx_start=0, tx_writedata=0, counter=0, last_owner=3 (requester 0 highest priority).
REQ-029 Reset mid-transfer SHALL abandon the transfer with no ack and no err.

Structure
REQ-030 A shared package SHALL hold the state encoding, N_REQ, and HEADER_BASE default.
REQ-031 Round-robin selection SHALL be one sub-module rr_pick (inputs req, last_owner; outputs valid, index).
REQ-032 The benches SHALL pair this block with the existing uart_tx (5208 clocks/bit) and a uart_rx monitor on the serial line.

Verification
REQ-033 Single: req=4'b0100, req_data[23:16]=8'h5C -> monitor receives 8'hA2 then 8'h5C; ack=4'b0100 pulses once; err never set.
REQ-034 Contention after reset: req=4'b1111, bytes 11/22/33/44 -> headers in order A0,A1,A2,A3 with matching payloads; exactly four ack pulses.
REQ-035 Fairness: req 0 and 3 held continuously -> grants alternate 0,3,0,3; no starvation.
REQ-036 Data change: alter req_data and drop req one cycle after grant -> original byte sent; ack still pulses.
REQ-037 Timeout: tx_done held low, TIMEOUT_CYCLES=100 -> err pulses once 100 cycles into WAIT_HDR; grant=0; no ack; next request served normally.
REQ-038 Reset during WAIT_DATA -> the cycle after reset shows all outputs 0; no ack or err; next req on requester 0 wins.
